// File: rtl/div_sched.sv
// div_sched: round-robin arbiter sharing one clock divider, switching divisors only on clk_out falling edges
module div_sched #(
  parameter int NREQ = 4,
  parameter int DIV_W = 32,
  parameter int MIN_DIV = 2,
  parameter int DEF_DIV = 4,
  parameter int HOLD_PERIODS = 4
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DIV_W-1:0]   req_div,
  input  logic                    clk_fb,
  output logic [DIV_W-1:0]        div_out,
  output logic [NREQ-1:0]         grant,
  output logic                    applied,
  output logic                    busy,
  output logic                    err_bad_div
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_PERIODS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n, cur, cur_n, win, idx;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [DIV_W-1:0] cap_div, cap_div_n, div_out_n;
  logic [DIV_W-1:0] slice [NREQ];
  logic [NREQ-1:0] grant_n, others;
  logic clk_fb_q, rise, fall, applied_n, err_n, held;
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_div[g*DIV_W +: DIV_W];
  end
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction
  assign rise = clk_fb & ~clk_fb_q;
  assign fall = ~clk_fb & clk_fb_q;
  assign others = req & ~(NREQ'(1) << cur);
  assign held = hold_cnt == HW'(HOLD_PERIODS);
  assign busy = state != IDLE;
  // pick the first asserted request at or after rr_ptr, wrapping around
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (req[idx]) win = idx;
    end
  end
  // next-state and output decisions for arbitration, edge wait and hold
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    cur_n = cur;
    hold_cnt_n = hold_cnt;
    cap_div_n = cap_div;
    div_out_n = div_out;
    grant_n = grant;
    applied_n = applied;
    err_n = 1'b0;
    case (state)
      IDLE: if (|req) begin
        if (slice[win] < DIV_W'(MIN_DIV)) begin
          err_n = 1'b1;
          rr_ptr_n = inc(win);
        end else begin
          cur_n = win;
          cap_div_n = slice[win];
          grant_n = NREQ'(1) << win;
          state_n = WAIT_EDGE;
        end
      end
      WAIT_EDGE: if (!req[cur]) begin
        grant_n = '0;
        rr_ptr_n = inc(cur);
        state_n = IDLE;
      end else if (fall) begin
        div_out_n = cap_div;
        applied_n = 1'b1;
        hold_cnt_n = '0;
        state_n = HOLD;
      end
      HOLD: if (held && (!req[cur] || |others)) begin
        grant_n = '0;
        applied_n = 1'b0;
        rr_ptr_n = inc(cur);
        state_n = IDLE;
      end else if (rise && !held) begin
        hold_cnt_n = hold_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur <= '0;
      hold_cnt <= '0;
      cap_div <= DIV_W'(DEF_DIV);
      div_out <= DIV_W'(DEF_DIV);
      grant <= '0;
      applied <= 1'b0;
      err_bad_div <= 1'b0;
      clk_fb_q <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      cur <= cur_n;
      hold_cnt <= hold_cnt_n;
      cap_div <= cap_div_n;
      div_out <= div_out_n;
      grant <= grant_n;
      applied <= applied_n;
      err_bad_div <= err_n;
      clk_fb_q <= clk_fb;
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: vector table, directed corner sequences and randomized model comparison for div_sched
module tb_div_sched;
  logic clk = 1'b0, reset = 1'b0, clk_fb = 1'b0;
  logic [3:0] req = 4'h0;
  logic [127:0] req_div = '0;
  logic [31:0] div_out;
  logic [3:0] grant;
  logic applied, busy, err_bad_div;
  int n_cmp = 0, n_bad = 0;
  bit fb_auto = 0, mdl_on = 0;
  int fb_cnt = 0;
  int m_own, m_ptr, m_rises;
  bit m_app, m_err, m_fbq;
  logic [31:0] m_div, m_cap;
  typedef struct {
    logic [3:0] r;
    logic [127:0] rd;
    logic fb;
    logic [3:0] g;
    logic a;
    logic [31:0] dv;
    logic e;
  } vec_t;
  vec_t tv[$];

  div_sched #(.NREQ(4), .DIV_W(32), .MIN_DIV(2), .DEF_DIV(4), .HOLD_PERIODS(4)) dut (
    .clk_in(clk), .reset(reset), .req(req), .req_div(req_div), .clk_fb(clk_fb),
    .div_out(div_out), .grant(grant), .applied(applied), .busy(busy), .err_bad_div(err_bad_div)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk(input logic [31:0] d3, input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input logic [3:0] r, input logic [127:0] rd, input logic fb, input logic [3:0] g, input logic a, input logic [31:0] dv, input logic e);
    vec_t v;
    v.r = r; v.rd = rd; v.fb = fb; v.g = g; v.a = a; v.dv = dv; v.e = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_ptr = 0; m_rises = 0; m_app = 0; m_err = 0; m_fbq = 0;
    m_div = 32'd4; m_cap = 32'd4;
  endtask

  task automatic m_step();
    bit rise, fall;
    int w;
    logic [31:0] d;
    rise = clk_fb && !m_fbq;
    fall = !clk_fb && m_fbq;
    m_fbq = clk_fb;
    m_err = 0;
    if (m_own < 0) begin
      if (req != 0) begin
        w = -1;
        for (int i = 0; i < 4; i++)
          if (w < 0 && req[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
        d = req_div[w*32 +: 32];
        if (d < 2) begin
          m_err = 1;
          m_ptr = (w + 1) % 4;
        end else begin
          m_own = w;
          m_cap = d;
        end
      end
    end else if (!m_app) begin
      if (!req[m_own]) begin
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
      end else if (fall) begin
        m_div = m_cap;
        m_app = 1;
        m_rises = 0;
      end
    end else begin
      if (m_rises == 4 && (!req[m_own] || (req & ~(4'b1 << m_own)) != 0)) begin
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
        m_app = 0;
      end else if (rise && m_rises < 4) begin
        m_rises++;
      end
    end
  endtask

  task automatic cyc();
    if (fb_auto) begin
      fb_cnt++;
      if (fb_cnt == 3) begin
        fb_cnt = 0;
        clk_fb = !clk_fb;
      end
    end
    @(posedge clk);
    if (mdl_on) m_step();
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] r8, rb;
    logic [3:0] eg;
    int n, w;
    r8 = mk(32'd0, 32'd0, 32'd0, 32'd8);
    rb = mk(32'd0, 32'd16, 32'd1, 32'd0);
    add(4'h0, r8, 1'b0, 4'h0, 1'b0, 32'd4, 1'b0);
    add(4'h1, r8, 1'b0, 4'h1, 1'b0, 32'd4, 1'b0);
    add(4'h1, r8, 1'b1, 4'h1, 1'b0, 32'd4, 1'b0);
    add(4'h1, r8, 1'b0, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h1, r8, 1'b1, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h1, r8, 1'b0, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h1, r8, 1'b1, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h1, r8, 1'b0, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h1, r8, 1'b1, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h0, r8, 1'b0, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h0, r8, 1'b1, 4'h1, 1'b1, 32'd8, 1'b0);
    add(4'h0, r8, 1'b0, 4'h0, 1'b0, 32'd8, 1'b0);
    add(4'h2, rb, 1'b0, 4'h0, 1'b0, 32'd8, 1'b1);
    add(4'h4, rb, 1'b0, 4'h4, 1'b0, 32'd8, 1'b0);
    add(4'h4, rb, 1'b1, 4'h4, 1'b0, 32'd8, 1'b0);
    add(4'h4, rb, 1'b0, 4'h4, 1'b1, 32'd16, 1'b0);
    add(4'h0, rb, 1'b0, 4'h4, 1'b1, 32'd16, 1'b0);

    #12;
    chk("rst_div", div_out, 32'd4);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_flags", {29'd0, applied, busy, err_bad_div}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    chk("idle_div", div_out, 32'd4);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      req = tv[i].r;
      req_div = tv[i].rd;
      clk_fb = tv[i].fb;
      cyc();
      chk($sformatf("tv%0d_grant", i), 32'(grant), 32'(tv[i].g));
      chk($sformatf("tv%0d_applied", i), 32'(applied), 32'(tv[i].a));
      chk($sformatf("tv%0d_div", i), div_out, tv[i].dv);
      chk($sformatf("tv%0d_err", i), 32'(err_bad_div), 32'(tv[i].e));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].g != 4'h0));
    end

    #2;
    reset = 1'b0;
    #1;
    chk("arst_div", div_out, 32'd4);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_flags", {30'd0, applied, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    fb_auto = 1;
    req = 4'hf;
    req_div = mk(32'd12, 32'd10, 32'd8, 32'd6);
    cyc();
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      eg = 4'b1 << w;
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(eg));
      n = 0;
      while (!applied && n < 200) begin cyc(); n++; end
      chk($sformatf("rr%0d_applied_tmo", k), 32'(n < 200), 32'd1);
      chk($sformatf("rr%0d_div", k), div_out, 32'(6 + 2 * w));
      req[w] = 1'b0;
      n = 0;
      while (grant != 4'h0 && n < 200) begin cyc(); n++; end
      chk($sformatf("rr%0d_release_tmo", k), 32'(n < 200), 32'd1);
      chk($sformatf("rr%0d_bubble", k), {27'd0, busy, grant}, 32'd0);
      req[w] = 1'b1;
      cyc();
    end

    req = 4'h0;
    n = 0;
    while (busy && n < 200) begin cyc(); n++; end
    chk("ab_idle_tmo", 32'(n < 200), 32'd1);
    fb_auto = 0;
    clk_fb = 1'b0;
    cyc();
    cyc();
    req = 4'h1;
    req_div = mk(32'd0, 32'd0, 32'd0, 32'd32);
    cyc();
    chk("ab_grant", 32'(grant), 32'd1);
    cyc();
    cyc();
    chk("ab_wait_applied", 32'(applied), 32'd0);
    req = 4'h0;
    cyc();
    chk("ab_grant0", 32'(grant), 32'd0);
    chk("ab_applied", 32'(applied), 32'd0);
    chk("ab_div", div_out, 32'd6);
    chk("ab_busy", 32'(busy), 32'd0);
    req = 4'h1;
    cyc();
    chk("aw_grant", 32'(grant), 32'd1);
    clk_fb = 1'b1;
    cyc();
    chk("aw_applied_pre", 32'(applied), 32'd0);
    clk_fb = 1'b0;
    req = 4'h0;
    cyc();
    chk("aw_grant0", 32'(grant), 32'd0);
    chk("aw_applied", 32'(applied), 32'd0);
    chk("aw_div", div_out, 32'd6);

    reset = 1'b0;
    clk_fb = 1'b0;
    req = 4'h0;
    req_div = '0;
    cyc();
    reset = 1'b1;
    m_reset();
    mdl_on = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) req_div[$urandom_range(0, 3)*32 +: 32] = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) clk_fb = !clk_fb;
      cyc();
      chk("rnd_grant", 32'(grant), (m_own < 0) ? 32'd0 : 32'(4'b1 << m_own));
      chk("rnd_applied", 32'(applied), 32'(m_app));
      chk("rnd_div", div_out, m_div);
      chk("rnd_err", 32'(err_bad_div), 32'(m_err));
      chk("rnd_busy", 32'(busy), 32'(m_own >= 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one programmable clock divider (`my_divider`) between NREQ requesters.
- Each requester asks for a divisor value. The scheduler grants one requester at a time.
- The granted divisor is applied only at a `clk_out` low-phase boundary, so the output clock never sees a mid-period divisor change.
- Sits between client blocks and the divider's `div` input, and observes the divider's `clk_out` as feedback.

Parameters:
- NREQ, 4: number of requesters.
- DIV_W, 32: divisor width.
- MIN_DIV, 2: smallest legal divisor; smaller requests are rejected.
- DEF_DIV, 4: `div_out` value after reset.
- HOLD_PERIODS, 4: minimum `clk_out` rising edges a grant is held once applied.

Ports:
- clk_in  input  1  system clock; the divider runs on the same clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  level request per requester.
- req_div  input  NREQ*DIV_W  requested divisor; slice i = bits [i*DIV_W +: DIV_W].
- clk_fb  input  1  divider `clk_out`, synchronous to `clk_in`.
- div_out  output  DIV_W  divisor driven to the divider's `div` input.
- grant  output  NREQ  one-hot grant; all zeros when idle.
- applied  output  1  high while the granted divisor is in effect.
- busy  output  1  high in any state other than IDLE.
- err_bad_div  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - div_out=DEF_DIV, grant=0, applied=0, busy=0, err_bad_div=0
  - state=IDLE, rr_ptr=0, hold_cnt=0, clk_fb_q=0
- Edge detection:
  - clk_fb_q is `clk_fb` registered on `clk_in`.
  - rise = clk_fb & ~clk_fb_q; fall = ~clk_fb & clk_fb_q.
- States: IDLE, WAIT_EDGE, HOLD.
- IDLE:
  - If req != 0, the winner w is the first asserted index at or after rr_ptr, wrapping NREQ-1 -> 0. Capture cap_div = req_div slice w.
  - If cap_div < MIN_DIV: pulse err_bad_div for one cycle, no grant, rr_ptr = (w+1) mod NREQ, stay IDLE.
  - Otherwise: grant = one-hot(w) from the next edge, go to WAIT_EDGE.
  - Latency: req high at edge t gives grant visible after edge t.
- WAIT_EDGE:
  - On the cycle where fall=1: div_out <= cap_div, applied <= 1, hold_cnt <= 0, go to HOLD.
  - If req[w] drops before fall: abort to IDLE, grant=0, div_out unchanged, rr_ptr=(w+1) mod NREQ.
  - If fall and req[w]=0 occur in the same cycle, abort wins.
- HOLD:
  - hold_cnt increments on each rise, saturating at HOLD_PERIODS.
  - Before hold_cnt reaches HOLD_PERIODS, the grant is kept even if req[w] drops.
  - Once hold_cnt == HOLD_PERIODS, release when req[w]=0 or any other req bit is high.
  - Release: grant=0, applied=0, rr_ptr=(w+1) mod NREQ, go to IDLE.
  - Otherwise stay in HOLD. The sole requester may keep the divider indefinitely.
- Re-arbitration:
  - Every release passes through IDLE for at least one cycle, so there is a one-cycle bubble with grant=0 between grants.
  - div_out retains the last applied value while idle.
- Granted requester's req_div is captured once in IDLE; later changes are ignored until a new grant.
- busy = (state != IDLE).
- Grant is always one-hot or zero.
- req_div values are unsigned, full DIV_W width, no truncation.

Test Plan:
- Reset check: reset=0 then released, no req -> div_out=4, grant=0, busy=0; after 50 cycles div_out still 4.
- Single grant: req=0001, slice0=8 -> grant=0001 next cycle; div_out becomes 8 on the first clk_fb falling edge; applied=1; held for at least 4 clk_fb rising edges.
- Round-robin: req=1111, slices=6,8,10,12, each requester drops req after applied -> grants in order 0001, 0010, 0100, 1000, 0001, with grant=0 for one cycle between each.
- Bad divisor: req=0010, slice1=1 -> err_bad_div pulses once, grant stays 0; then req=0100, slice2=16 -> grant=0100 (rr_ptr advanced).
- Abort: req=0001, slice0=32, drop req before the clk_fb falling edge -> grant returns to 0, div_out unchanged, applied never asserts.
- Async reset mid-HOLD: assert reset while in HOLD with div_out=16 -> immediately div_out=4, grant=0, applied=0; after release the next request arbitrates from index 0.
